sram_frame_reader: RTL and testbench

- Read-side client (initiator) of the single-port animation SRAM (1-cycle read latency, we/en/addr/data interface).
- On `start`, scans one FRAME_W x FRAME_H animation frame beginning at `base_addr`, in raster order.
- Issues SRAM reads and absorbs the read latency through an internal FIFO.
- Delivers pixels as a valid/ready stream with end-of-line and end-of-frame markers to the display/compose logic.

---
 rtl/sram_frame_reader_pkg.sv | 28 ++
 rtl/sram_frame_reader_if.sv | 33 +++
 rtl/sram_frame_reader_pix_fifo.sv | 70 +++++++
 rtl/sram_frame_reader.sv | 155 +++++++++++++++
 tb/tb_sram_frame_reader.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_frame_reader_pkg.sv
// Shared animation definitions: pixel type, default frame geometry, reader
// FSM states and the per-pixel line/frame tag.
package sram_frame_reader_pkg;

    localparam int DATA_WIDTH   = 12;
    localparam int FRAME_W      = 64;
    localparam int FRAME_H      = 64;
    localparam int FRAME_PIXELS = FRAME_W * FRAME_H;

    typedef logic [DATA_WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic eol;
        logic eof;
    } tag_t;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram_frame_reader_if.sv
// Bus bundle of the frame reader: SRAM read port toward memory and the
// pixel stream toward the display/compose logic.
interface sram_frame_reader_if #(
    parameter int DATA_WIDTH = sram_frame_reader_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = 16
);
    logic                  sram_en;
    logic                  sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [DATA_WIDTH-1:0] sram_rdata;

    logic [DATA_WIDTH-1:0] pix_data;
    logic                  pix_valid;
    logic                  pix_ready;
    logic                  pix_eol;
    logic                  pix_eof;

    modport master (
        output sram_en, sram_we, sram_addr, sram_wdata,
        input  sram_rdata,
        output pix_data, pix_valid, pix_eol, pix_eof,
        input  pix_ready
    );

    modport slave (
        input  sram_en, sram_we, sram_addr, sram_wdata,
        output sram_rdata,
        input  pix_data, pix_valid, pix_eol, pix_eof,
        output pix_ready
    );

endinterface

// File: rtl/sram_frame_reader_pix_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the oldest entry, and a
// push into a full FIFO is allowed when a pop happens in the same cycle.
module sram_frame_reader_pix_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/sram_frame_reader.sv
// Reads one FRAME_W x FRAME_H frame from the animation SRAM in raster order
// and streams it out as valid/ready pixels tagged with end-of-line/frame.
module sram_frame_reader #(
    parameter int DATA_WIDTH = sram_frame_reader_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = 16,
    parameter int FRAME_W    = sram_frame_reader_pkg::FRAME_W,
    parameter int FRAME_H    = sram_frame_reader_pkg::FRAME_H,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    sram_frame_reader_if.master   bus
);
    import sram_frame_reader_pkg::*;

    localparam int N_PIX = FRAME_W * FRAME_H;
    localparam int X_W   = clog2_min1(FRAME_W);
    localparam int Y_W   = clog2_min1(FRAME_H);
    localparam int N_W   = clog2_min1(N_PIX);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int FW    = DATA_WIDTH + 2;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [X_W-1:0]        x_q, x_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic [N_W-1:0]        issued_q, issued_d;
    logic                  inflight_q;
    tag_t                  tag_q;

    logic                  issue;
    logic                  last_x;
    logic                  last_y;
    logic                  last_issue;
    logic [CNT_W-1:0]      credit_used;

    logic [FW-1:0]         fifo_din;
    logic [FW-1:0]         fifo_dout;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_pop;

    // Credit covers both stored entries and the read still in the SRAM pipe,
    // so the FIFO can never be pushed while full.
    always_comb begin
        credit_used = fifo_count + CNT_W'(inflight_q);
        issue       = (state_q == ST_ISSUE) && (credit_used < CNT_W'(FIFO_DEPTH)) && !fifo_full;
        last_x      = (x_q == X_W'(FRAME_W - 1));
        last_y      = (y_q == Y_W'(FRAME_H - 1));
        last_issue  = issue && (issued_q == N_W'(N_PIX - 1));
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        x_d      = x_q;
        y_d      = y_q;
        issued_d = issued_q;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_ISSUE;
                    addr_d   = base_addr;
                    x_d      = '0;
                    y_d      = '0;
                    issued_d = '0;
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    issued_d = issued_q + N_W'(1);
                    if (last_x) begin
                        x_d = '0;
                        y_d = last_y ? '0 : (y_q + Y_W'(1));
                    end else begin
                        x_d = x_q + X_W'(1);
                    end
                    if (last_issue) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !inflight_q) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            issued_q   <= issued_d;
            inflight_q <= issue;
            if (issue) begin
                tag_q <= '{eol: last_x, eof: last_x && last_y};
            end
        end
    end

    // The tag travels one cycle behind its read so it lines up with the data.
    assign fifo_din = {bus.sram_rdata, tag_q.eol, tag_q.eof};
    assign fifo_pop = !fifo_empty && bus.pix_ready;

    sram_frame_reader_pix_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_pix_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_q),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign busy = (state_q != ST_IDLE);

    assign bus.sram_en    = issue;
    assign bus.sram_we    = 1'b0;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = '0;

    // Qualify the head with occupancy so stale storage never leaks out.
    assign bus.pix_valid = !fifo_empty;
    assign bus.pix_data  = fifo_empty ? '0 : fifo_dout[FW-1:2];
    assign bus.pix_eol   = !fifo_empty && fifo_dout[1];
    assign bus.pix_eof   = !fifo_empty && fifo_dout[0];

endmodule

// File: tb/tb_sram_frame_reader.sv
// Self-checking bench for sram_frame_reader on a 4x2 frame: table of frame
// runs under several ready patterns, checked against a queue-based model.
`timescale 1ns/1ps
module tb_sram_frame_reader;
    import sram_frame_reader_pkg::*;

    localparam int W      = 4;
    localparam int H      = 2;
    localparam int N      = W * H;
    localparam int DEPTH  = 4;
    localparam int BUDGET = 400;

    localparam int M_ALWAYS = 0;
    localparam int M_TOGGLE = 1;
    localparam int M_HOLD   = 2;
    localparam int M_RAND   = 3;

    typedef struct {
        logic [15:0] base;
        int          mode;
        int          restart_at;
        int          exp_first;
        int          exp_done;
        bit          rand_data;
    } vec_t;

    typedef struct {
        pixel_t data;
        logic   eol;
        logic   eof;
    } pix_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic        busy;
    logic        done;

    sram_frame_reader_if #(.DATA_WIDTH(12), .ADDR_WIDTH(16)) bus();

    sram_frame_reader #(
        .DATA_WIDTH (12),
        .ADDR_WIDTH (16),
        .FRAME_W    (W),
        .FRAME_H    (H),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: one-cycle read latency.
    pixel_t mem [65536];
    pixel_t rdata_q;
    always @(posedge clk) begin
        if (bus.sram_en) rdata_q <= mem[bus.sram_addr];
    end
    assign bus.sram_rdata = rdata_q;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic ready_for(input int mode, input int rel);
        case (mode)
            M_ALWAYS: return 1'b1;
            M_TOGGLE: return (rel % 2) == 0;
            M_HOLD:   return rel > 20;
            default:  return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    // Monitor state
    pix_t        exp_q[$];
    pix_t        mon_e;
    bit          mon_on = 0;
    int          t0, mon_rel;
    logic [15:0] cur_base;
    int          n_en, n_xfer, done_cnt, done_rel, first_rel, en_by20;
    int          busy_rel1, busy_after_done;
    bit          prev_stall = 0;
    logic [13:0] prev_word, mon_word;

    always @(negedge clk) begin
        if (mon_on) begin
            mon_rel  = cyc - t0;
            mon_word = {bus.pix_data, bus.pix_eol, bus.pix_eof};
            if (prev_stall) begin
                check("hold_valid", 32'(bus.pix_valid), 1);
                check("hold_word", 32'(mon_word), 32'(prev_word));
            end
            if (bus.pix_valid && first_rel < 0) first_rel = mon_rel;
            if (bus.sram_en) begin
                check("read_addr", 32'(bus.sram_addr), 32'(16'(cur_base + n_en)));
                check("read_we", 32'(bus.sram_we), 0);
                n_en++;
                if (mon_rel <= 20) en_by20++;
            end
            if (bus.pix_valid && bus.pix_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_pixel", n_xfer + 1, N);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pixel", 32'(mon_word), 32'({mon_e.data, mon_e.eol, mon_e.eof}));
                end
                n_xfer++;
            end
            check("outstanding_le_depth", 32'(n_en - n_xfer <= DEPTH), 1);
            if (mon_rel == 1) busy_rel1 = int'(busy);
            if (done_cnt > 0 && mon_rel == done_rel + 1) busy_after_done = int'(busy);
            if (done) begin
                if (done_cnt == 0) done_rel = mon_rel;
                done_cnt++;
            end
            prev_stall = bus.pix_valid && !bus.pix_ready;
            prev_word  = mon_word;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic run_frame(input int row, input vec_t v);
        int k;
        bit fin;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            pix_t e;
            e.data = mem[16'(v.base + i)];
            e.eol  = (i % W) == W - 1;
            e.eof  = (i == N - 1);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        t0 = cyc; cur_base = v.base;
        n_en = 0; n_xfer = 0; done_cnt = 0; done_rel = -1; first_rel = -1;
        en_by20 = 0; busy_rel1 = 0; busy_after_done = -1; prev_stall = 0;
        mon_on = 1;
        start = 1'b1;
        base_addr = v.base;
        bus.pix_ready = ready_for(v.mode, 0);
        k = 0;
        fin = 0;
        while (!fin) begin
            @(posedge clk); #1;
            k++;
            start = (k == v.restart_at);
            base_addr = start ? 16'h0200 : v.base;
            bus.pix_ready = ready_for(v.mode, k);
            if (done_cnt > 0 && k >= done_rel + 5) fin = 1;
            if (k >= BUDGET) fin = 1;
        end
        @(negedge clk); #1;
        mon_on = 0;
        start = 1'b0;
        check("frame_timeout", 32'(k < BUDGET), 1);
        check("done_count", done_cnt, 1);
        check("pixel_count", n_xfer, N);
        check("missing_pixels", exp_q.size(), 0);
        check("read_count", n_en, N);
        check("busy_cycle1", busy_rel1, 1);
        check("busy_after_done", busy_after_done, 0);
        if (v.exp_first >= 0) check("first_valid_cycle", first_rel, v.exp_first);
        if (v.exp_done >= 0) check("done_cycle", done_rel, v.exp_done);
        if (v.mode == M_HOLD) check("reads_while_stalled", en_by20, DEPTH);
        $display("frame %0d: base=0x%04h mode=%0d pixels=%0d reads=%0d done_cycle=%0d",
                 row, v.base, v.mode, n_xfer, n_en, done_rel);
    endtask

    task automatic reset_mid_frame();
        int quiet_bad;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 16'h0100;
        bus.pix_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == 4) check("pre_reset_busy", 32'(busy), 1);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_busy", 32'(busy), 0);
        check("reset_valid", 32'(bus.pix_valid), 0);
        check("reset_sram_en", 32'(bus.sram_en), 0);
        check("reset_done", 32'(done), 0);
        quiet_bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || bus.pix_valid || busy || bus.sram_en) quiet_bad++;
        end
        check("post_reset_quiet", quiet_bad, 0);
        $display("reset mid-frame: quiet_cycles_bad=%0d", quiet_bad);
    endtask

    initial begin
        vec_t vecs[8];
        vec_t fresh;
        bus.pix_ready = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 12'(a);

        //            base      mode      restart first done rand
        vecs[0] = '{16'h0100, M_ALWAYS, -1,  3, 11, 1'b0};
        vecs[1] = '{16'h0100, M_TOGGLE, -1,  3, -1, 1'b0};
        vecs[2] = '{16'h0100, M_HOLD,   -1,  3, -1, 1'b0};
        vecs[3] = '{16'hFFFE, M_ALWAYS, -1,  3, 11, 1'b0};
        vecs[4] = '{16'h0100, M_ALWAYS,  5,  3, 11, 1'b0};
        vecs[5] = '{16'h0100, M_ALWAYS, 11,  3, 11, 1'b0};
        vecs[6] = '{16'($urandom_range(0, 65535)), M_RAND, -1, 3, -1, 1'b1};
        vecs[7] = '{16'($urandom_range(0, 65535)), M_RAND, -1, 3, -1, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sram_en", 32'(bus.sram_en), 0);
        check("rst_sram_addr", 32'(bus.sram_addr), 0);
        check("rst_pix_valid", 32'(bus.pix_valid), 0);
        check("rst_pix_eol", 32'(bus.pix_eol), 0);
        check("rst_pix_eof", 32'(bus.pix_eof), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int r = 0; r < 8; r++) begin
            if (vecs[r].rand_data) begin
                for (int i = 0; i < N; i++) mem[16'(vecs[r].base + i)] = 12'($urandom);
            end
            run_frame(r, vecs[r]);
        end

        reset_mid_frame();
        fresh = '{16'h0100, M_ALWAYS, -1, 3, 11, 1'b0};
        run_frame(8, fresh);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
